// File: rtl/types_pkg.sv
// Shared RV32I types: opcodes, funct fields, immediate bit positions and the
// instruction-memory loader state encoding.
package types_pkg;

    localparam int ADDR_WIDTH = 9;
    localparam int XLEN       = 32;

    typedef logic [XLEN-1:0]        word_t;
    typedef logic signed [XLEN-1:0] signed_word_t;
    typedef logic [4:0]             reg_addr_t;

    typedef enum logic [6:0] {
        OP_I_LOAD    = 7'h03,
        OP_I_ARITH   = 7'h13,
        OP_S_TYPE    = 7'h23,
        OP_R_TYPE    = 7'h33,
        OP_RV64_TYPE = 7'h3B,
        OP_B_TYPE    = 7'h63,
        OP_J_TYPE    = 7'h6F
    } opcode_e;

    typedef enum logic [2:0] {
        F3_ADD_SUB = 3'd0,
        F3_SLL     = 3'd1,
        F3_SLT     = 3'd2,
        F3_SLTU    = 3'd3,
        F3_XOR     = 3'd4,
        F3_SRL_SRA = 3'd5,
        F3_OR      = 3'd6,
        F3_AND     = 3'd7
    } funct3_e;

    typedef enum logic [6:0] {
        F7_BASE = 7'h00,
        F7_ALT  = 7'h20
    } funct7_e;

    // Immediate bit positions shared with the decoder's field slicing.
    localparam int IMM_I_MSB     = 11;
    localparam int IMM_SHAMT_MSB = 4;
    localparam int IMM_S_LO_MSB  = 4;
    localparam int IMM_S_HI_LSB  = 5;
    localparam int IMM_B_SIGN    = 12;
    localparam int IMM_B_BIT11   = 11;
    localparam int IMM_B_MID_MSB = 10;
    localparam int IMM_B_MID_LSB = 5;
    localparam int IMM_B_LO_MSB  = 4;
    localparam int IMM_J_SIGN    = 20;
    localparam int IMM_J_HI_MSB  = 19;
    localparam int IMM_J_HI_LSB  = 12;
    localparam int IMM_J_BIT11   = 11;
    localparam int IMM_J_LO_MSB  = 10;

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_LOAD  = 3'd1,
        LDR_WRITE = 3'd2,
        LDR_DONE  = 3'd3,
        LDR_FULL  = 3'd4
    } loader_state_e;

endpackage

// File: rtl/rv32i_instr_encoder.sv
// Combinational RV32I field packer (R/I/S/B/J), the inverse of the decoder's
// field slicing. Flags any opcode outside the supported RV32I subset.
module rv32i_instr_encoder
    import types_pkg::*;
(
    input  logic [6:0]   op,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    input  reg_addr_t    rd,
    input  reg_addr_t    rs1,
    input  reg_addr_t    rs2,
    input  signed_word_t imm,
    output word_t        word,
    output logic         illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op)
            OP_R_TYPE: begin
                word = {funct7, rs2, rs1, funct3, rd, op};
            end
            OP_I_LOAD: begin
                word = {imm[IMM_I_MSB:0], rs1, funct3, rd, op};
            end
            OP_I_ARITH: begin
                // Shift-immediates carry funct7 in the upper bits to select SRL/SRA.
                if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) begin
                    word = {funct7, imm[IMM_SHAMT_MSB:0], rs1, funct3, rd, op};
                end else begin
                    word = {imm[IMM_I_MSB:0], rs1, funct3, rd, op};
                end
            end
            OP_S_TYPE: begin
                word = {imm[IMM_I_MSB:IMM_S_HI_LSB], rs2, rs1, funct3,
                        imm[IMM_S_LO_MSB:0], op};
            end
            OP_B_TYPE: begin
                word = {imm[IMM_B_SIGN], imm[IMM_B_MID_MSB:IMM_B_MID_LSB], rs2, rs1,
                        funct3, imm[IMM_B_LO_MSB:1], imm[IMM_B_BIT11], op};
            end
            OP_J_TYPE: begin
                word = {imm[IMM_J_SIGN], imm[IMM_J_LO_MSB:1], imm[IMM_J_BIT11],
                        imm[IMM_J_HI_MSB:IMM_J_HI_LSB], rd, op};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Packs instruction field bundles into RV32I words and writes them to sequential
// instruction-memory addresses. Optional XOR checksum: INSTR_LOADER_CHECKSUM_EN.
//
// Stream handshake: a bundle transfers on a rising edge where in_valid && in_ready;
// in_valid may be held without ready, and in_ready is high only in LOAD.
module instr_mem_loader
    import types_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [6:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err,
    output loader_state_e     state_dbg
`ifdef INSTR_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_e state;
    logic          last_q;
    word_t         enc_word;
    logic          enc_illegal;

    rv32i_instr_encoder u_encoder (
        .op      (in_op),
        .funct3  (in_funct3),
        .funct7  (in_funct7),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LDR_IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            last_q     <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else if (start) begin
            // start wins over any handshake and cancels a pending write.
            state      <= LDR_LOAD;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            last_q     <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            case (state)
                LDR_IDLE: begin
                    in_ready <= 1'b0;
                end
                LDR_LOAD: begin
                    if (in_valid && in_ready) begin
                        if (enc_illegal) begin
                            // Illegal bundles are swallowed; only in_last can end the load.
                            err <= 1'b1;
                            if (in_last) begin
                                state    <= LDR_DONE;
                                in_ready <= 1'b0;
                                done     <= 1'b1;
                            end
                        end else begin
                            imem_wdata <= enc_word;
                            last_q     <= in_last;
                            imem_we    <= 1'b1;
                            in_ready   <= 1'b0;
                            state      <= LDR_WRITE;
                        end
                    end
                end
                LDR_WRITE: begin
                    imem_we   <= 1'b0;
                    imem_addr <= imem_addr + ADDR_W'(1);
                    count     <= count + (ADDR_W+1)'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
                    checksum  <= checksum ^ imem_wdata;
`endif
                    if (last_q) begin
                        state <= LDR_DONE;
                        done  <= 1'b1;
                    end else if (imem_addr == LAST_ADDR) begin
                        state <= LDR_FULL;
                        done  <= 1'b1;
                    end else begin
                        state    <= LDR_LOAD;
                        in_ready <= 1'b1;
                    end
                end
                LDR_DONE, LDR_FULL: begin
                    in_ready <= 1'b0;
                    done     <= 1'b1;
                end
                default: begin
                    state    <= LDR_IDLE;
                    in_ready <= 1'b0;
                    imem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: hand-encoded RV32I words, fill to FULL,
// start/reset aborts, and the optional checksum (INSTR_LOADER_CHECKSUM_EN).
module tb_instr_mem_loader;
    import types_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [6:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        imem_we;
    logic [8:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [9:0]  count;
    logic        done;
    logic        err;
    loader_state_e state_dbg;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_data[$];
    logic [8:0]  got_addr[$];

    instr_mem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .done       (done),
        .err        (err),
        .state_dbg  (state_dbg)
`ifdef INSTR_LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_data.push_back(imem_wdata);
            got_addr.push_back(imem_addr);
        end
    end

    // driver tasks: all called at posedge+1
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got_data.delete();
        got_addr.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic last);
        int waited;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({in_ready, imem_we, done, err} !== 4'b0 || imem_addr !== 9'd0 ||
            imem_wdata !== 32'd0 || count !== 10'd0 || state_dbg !== LDR_IDLE) begin
            bad++;
            $display("FAIL reset_values: rdy=%b we=%b done=%b err=%b addr=%0d wdata=%h count=%0d st=%0d required all 0",
                     in_ready, imem_we, done, err, imem_addr, imem_wdata, count, state_dbg);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        // IDLE ignores in_valid
        in_op = OP_I_ARITH; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (got_data.size() != 0 || in_ready !== 1'b0 || state_dbg !== LDR_IDLE) begin
            bad++;
            $display("FAIL idle_ignore: writes=%0d rdy=%b st=%0d required 0 0 IDLE",
                     got_data.size(), in_ready, state_dbg);
        end
    endtask

    task automatic test_program();
        pulse_start();
        total++;
        if (in_ready !== 1'b1 || count !== 10'd0 || state_dbg !== LDR_LOAD) begin
            bad++;
            $display("FAIL start_load: rdy=%b count=%0d st=%0d required 1 0 LOAD",
                     in_ready, count, state_dbg);
        end
        // addi x1,x0,5
        send(OP_I_ARITH, 5'd1, 5'd0, 5'd0, F3_ADD_SUB, F7_BASE, 32'd5, 1'b0);
        total++;
        if (imem_we !== 1'b1 || imem_addr !== 9'd0 || imem_wdata !== 32'h00500093 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL addi_write: we=%b addr=%0d wdata=%h rdy=%b required 1 0 00500093 0",
                     imem_we, imem_addr, imem_wdata, in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (imem_we !== 1'b0 || count !== 10'd1) begin
            bad++;
            $display("FAIL addi_after: we=%b count=%0d required 0 1", imem_we, count);
        end
        // add x3,x1,x2
        send(OP_R_TYPE, 5'd3, 5'd1, 5'd2, F3_ADD_SUB, F7_BASE, 32'd0, 1'b0);
        total++;
        if (imem_we !== 1'b1 || imem_addr !== 9'd1 || imem_wdata !== 32'h002081B3) begin
            bad++;
            $display("FAIL add_write: we=%b addr=%0d wdata=%h required 1 1 002081b3",
                     imem_we, imem_addr, imem_wdata);
        end
        // sw x2,8(x1)
        send(OP_S_TYPE, 5'd0, 5'd1, 5'd2, F3_SLT, F7_BASE, 32'd8, 1'b0);
        total++;
        if (imem_we !== 1'b1 || imem_addr !== 9'd2 || imem_wdata !== 32'h0020A423) begin
            bad++;
            $display("FAIL sw_write: we=%b addr=%0d wdata=%h required 1 2 0020a423",
                     imem_we, imem_addr, imem_wdata);
        end
        @(posedge clk); #1;
        total++;
        if (count !== 10'd3) begin
            bad++;
            $display("FAIL count3: count=%0d required 3", count);
        end
        // beq x1,x2,-4
        send(OP_B_TYPE, 5'd0, 5'd1, 5'd2, F3_ADD_SUB, F7_BASE, 32'hFFFFFFFC, 1'b0);
        total++;
        if (imem_addr !== 9'd3 || imem_wdata !== 32'hFE208EE3) begin
            bad++;
            $display("FAIL beq_write: addr=%0d wdata=%h required 3 fe208ee3", imem_addr, imem_wdata);
        end
        // jal x1,8 (last)
        send(OP_J_TYPE, 5'd1, 5'd0, 5'd0, F3_ADD_SUB, F7_BASE, 32'd8, 1'b1);
        total++;
        if (imem_addr !== 9'd4 || imem_wdata !== 32'h008000EF || imem_we !== 1'b1) begin
            bad++;
            $display("FAIL jal_write: we=%b addr=%0d wdata=%h required 1 4 008000ef",
                     imem_we, imem_addr, imem_wdata);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b1 || in_ready !== 1'b0 || count !== 10'd5 || state_dbg !== LDR_DONE) begin
            bad++;
            $display("FAIL last_done: done=%b rdy=%b count=%0d st=%0d required 1 0 5 DONE",
                     done, in_ready, count, state_dbg);
        end
    endtask

    task automatic test_shift_illegal();
        pulse_start();
        // srai x5,x6,3
        send(OP_I_ARITH, 5'd5, 5'd6, 5'd0, F3_SRL_SRA, F7_ALT, 32'd3, 1'b0);
        total++;
        if (imem_addr !== 9'd0 || imem_wdata !== 32'h40335293) begin
            bad++;
            $display("FAIL srai_write: addr=%0d wdata=%h required 0 40335293", imem_addr, imem_wdata);
        end
        @(posedge clk); #1;
        send(7'h3B, 5'd1, 5'd2, 5'd3, F3_ADD_SUB, F7_BASE, 32'd0, 1'b0);
        total++;
        if (imem_we !== 1'b0 || err !== 1'b1 || in_ready !== 1'b1 || state_dbg !== LDR_LOAD) begin
            bad++;
            $display("FAIL illegal_op: we=%b err=%b rdy=%b st=%0d required 0 1 1 LOAD",
                     imem_we, err, in_ready, state_dbg);
        end
        send(OP_I_ARITH, 5'd1, 5'd0, 5'd0, F3_ADD_SUB, F7_BASE, 32'd5, 1'b0);
        total++;
        if (imem_addr !== 9'd1 || imem_wdata !== 32'h00500093 || got_data.size() != 1) begin
            bad++;
            $display("FAIL after_illegal: addr=%0d wdata=%h writes=%0d required 1 00500093 1",
                     imem_addr, imem_wdata, got_data.size());
        end
        @(posedge clk); #1;
        send(7'h7F, 5'd0, 5'd0, 5'd0, F3_ADD_SUB, F7_BASE, 32'd0, 1'b1);
        total++;
        if (done !== 1'b1 || in_ready !== 1'b0 || count !== 10'd2 || err !== 1'b1 || got_data.size() != 2) begin
            bad++;
            $display("FAIL illegal_last: done=%b rdy=%b count=%0d err=%b writes=%0d required 1 0 2 1 2",
                     done, in_ready, count, err, got_data.size());
        end
        pulse_start();
        total++;
        if (err !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL start_clear_err: err=%b done=%b required 0 0", err, done);
        end
    endtask

    task automatic test_full();
        int mism;
        pulse_start();
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back(({20'd0, 12'(i)} << 20) | 32'h00000093);
            send(OP_I_ARITH, 5'd1, 5'd0, 5'd0, F3_ADD_SUB, F7_BASE, 32'(i), 1'b0);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b1 || count !== 10'd512 || in_ready !== 1'b0 || state_dbg !== LDR_FULL) begin
            bad++;
            $display("FAIL full_state: done=%b count=%0d rdy=%b st=%0d required 1 512 0 FULL",
                     done, count, in_ready, state_dbg);
        end
        mism = 0;
        for (int i = 0; i < 512 && i < got_data.size(); i++) begin
            if (got_data[i] !== exp_q[i] || got_addr[i] !== 9'(i)) mism++;
        end
        total++;
        if (got_data.size() != 512 || mism != 0) begin
            bad++;
            $display("FAIL full_words: writes=%0d mismatched=%0d required 512 0", got_data.size(), mism);
        end
        // 513th bundle must be held off
        in_op = OP_I_ARITH; in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (got_data.size() != 512 || in_ready !== 1'b0 || count !== 10'd512) begin
            bad++;
            $display("FAIL full_hold: writes=%0d rdy=%b count=%0d required 512 0 512",
                     got_data.size(), in_ready, count);
        end
        pulse_start();
        total++;
        if (done !== 1'b0 || count !== 10'd0 || in_ready !== 1'b1 || imem_addr !== 9'd0) begin
            bad++;
            $display("FAIL full_restart: done=%b count=%0d rdy=%b addr=%0d required 0 0 1 0",
                     done, count, in_ready, imem_addr);
        end
    endtask

    task automatic test_start_abort();
        pulse_start();
        send(OP_I_ARITH, 5'd1, 5'd0, 5'd0, F3_ADD_SUB, F7_BASE, 32'd5, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (imem_we !== 1'b0 || imem_addr !== 9'd0 || count !== 10'd0 ||
            in_ready !== 1'b1 || state_dbg !== LDR_LOAD) begin
            bad++;
            $display("FAIL start_abort: we=%b addr=%0d count=%0d rdy=%b st=%0d required 0 0 0 1 LOAD",
                     imem_we, imem_addr, count, in_ready, state_dbg);
        end
        // async reset during WRITE
        send(OP_R_TYPE, 5'd3, 5'd1, 5'd2, F3_ADD_SUB, F7_BASE, 32'd0, 1'b0);
        got_data.delete();
        rst_n = 1'b0;
        #1;
        total++;
        if (imem_we !== 1'b0 || count !== 10'd0 || state_dbg !== LDR_IDLE || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_write: we=%b count=%0d st=%0d rdy=%b required 0 0 IDLE 0",
                     imem_we, count, state_dbg, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (got_data.size() != 0) begin
            bad++;
            $display("FAIL reset_no_write: writes=%0d required 0", got_data.size());
        end
    endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        total++;
        if (checksum !== 32'd0) begin
            bad++;
            $display("FAIL checksum_clear: checksum=%h required 0", checksum);
        end
        send(OP_I_ARITH, 5'd1, 5'd0, 5'd0, F3_ADD_SUB, F7_BASE, 32'd5, 1'b0);
        send(OP_R_TYPE, 5'd3, 5'd1, 5'd2, F3_ADD_SUB, F7_BASE, 32'd0, 1'b0);
        @(posedge clk); #1;
        total++;
        if (checksum !== 32'h00708120) begin
            bad++;
            $display("FAIL checksum_value: checksum=%h required 00708120", checksum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_program();
        test_shift_illegal();
        test_full();
        test_start_abort();
`ifdef INSTR_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
